// File: rtl/broadcast_probe_issuer_pkg.sv
// Shared types and constants for the broadcast probe issuer.
// Holds the FSM state encoding, the probe cap params and the default widths.
package broadcast_probe_issuer_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StProbe,
        StWait,
        StDone
    } state_e;

    localparam logic [1:0] TO_T = 2'd0;
    localparam logic [1:0] TO_B = 2'd1;
    localparam logic [1:0] TO_N = 2'd2;

    localparam int unsigned DEFAULT_ADDR_W = 26;
    localparam int unsigned DEFAULT_MSHR_W = 2;

endpackage

// File: rtl/broadcast_lowest_one.sv
// Combinational priority encoder.
// Returns the index and the one-hot of the lowest set bit of a mask.
module broadcast_lowest_one #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned IDX_W = 1
) (
    input  logic [WIDTH-1:0] mask_i,
    output logic [IDX_W-1:0] idx_o,
    output logic [WIDTH-1:0] onehot_o
);

    // Scan downwards so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

    assign onehot_o = mask_i & (~mask_i + 1'b1);

endmodule

// File: rtl/broadcast_probe_issuer.sv
// Issues one probe per client flagged by a filter response, counts ProbeAcks,
// and reports completion to the owning MSHR tracker once every ack is back.
module broadcast_probe_issuer
    import broadcast_probe_issuer_pkg::*;
#(
    parameter int unsigned N_CLIENTS = 1,
    parameter int unsigned ADDR_W    = DEFAULT_ADDR_W,
    parameter int unsigned MSHR_W    = DEFAULT_MSHR_W,
    parameter int unsigned CLIENT_W  = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 io_filter_valid,
    output logic                 io_filter_ready,
    input  logic [MSHR_W-1:0]    io_filter_bits_mshr,
    input  logic [ADDR_W-1:0]    io_filter_bits_address,
    input  logic [N_CLIENTS-1:0] io_filter_bits_allocOH,
    input  logic                 io_filter_bits_needT,
    output logic                 io_probe_valid,
    input  logic                 io_probe_ready,
    output logic [ADDR_W-1:0]    io_probe_bits_address,
    output logic [1:0]           io_probe_bits_param,
    output logic [CLIENT_W-1:0]  io_probe_bits_client,
    input  logic                 io_probeAck_valid,
    output logic                 io_done_valid,
    input  logic                 io_done_ready,
    output logic [MSHR_W-1:0]    io_done_bits_mshr,
    output logic                 io_error
);

    localparam int unsigned CNT_W = $clog2(N_CLIENTS + 1);

    state_e                 state_q, state_d;
    logic [N_CLIENTS-1:0]   pend_q, pend_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [MSHR_W-1:0]      mshr_q, mshr_d;
    logic                   need_t_q, need_t_d;
    logic                   err_q, err_d;
    logic                   probe_fire;
    logic [CLIENT_W-1:0]    low_idx;
    logic [N_CLIENTS-1:0]   low_oh;

    broadcast_lowest_one #(
        .WIDTH (N_CLIENTS),
        .IDX_W (CLIENT_W)
    ) u_lowest_one (
        .mask_i   (pend_q),
        .idx_o    (low_idx),
        .onehot_o (low_oh)
    );

    assign probe_fire = (state_q == StProbe) && io_probe_ready;

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        mshr_d   = mshr_q;
        need_t_d = need_t_q;
        err_d    = err_q;

        // Acks are counted in every state; an ack with nothing outstanding is an error.
        unique case ({probe_fire, io_probeAck_valid})
            2'b10: cnt_d = cnt_q + 1'b1;
            2'b01: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase

        unique case (state_q)
            StIdle: begin
                if (io_filter_valid) begin
                    addr_d   = io_filter_bits_address;
                    mshr_d   = io_filter_bits_mshr;
                    need_t_d = io_filter_bits_needT;
                    pend_d   = io_filter_bits_allocOH;
                    state_d  = (io_filter_bits_allocOH != '0) ? StProbe : StDone;
                end
            end
            StProbe: begin
                if (io_probe_ready) begin
                    pend_d = pend_q & ~low_oh;
                    if (pend_d == '0) begin
                        state_d = (cnt_d == '0) ? StDone : StWait;
                    end
                end
            end
            StWait: begin
                if (cnt_d == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (io_done_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            pend_q   <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
            mshr_q   <= '0;
            need_t_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            mshr_q   <= mshr_d;
            need_t_q <= need_t_d;
            err_q    <= err_d;
        end
    end

    assign io_filter_ready       = (state_q == StIdle);
    assign io_probe_valid        = (state_q == StProbe);
    assign io_done_valid         = (state_q == StDone);
    assign io_probe_bits_address = addr_q;
    assign io_probe_bits_param   = need_t_q ? TO_N : TO_B;
    assign io_probe_bits_client  = low_idx;
    assign io_done_bits_mshr     = mshr_q;
    assign io_error              = err_q;

endmodule

// File: tb/tb_broadcast_probe_issuer.sv
// Bench for broadcast_probe_issuer: a one-client and a four-client instance are
// checked every cycle against a transaction-level model plus pinned literal values.
module tb_broadcast_probe_issuer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        fv = 1'b0;
    logic [1:0]  mshr = '0;
    logic [25:0] addr = '0;
    logic [3:0]  alloc = '0;
    logic        need_t = 1'b0;
    logic        pready = 1'b1;
    logic        ack = 1'b0;
    logic        dready = 1'b1;
    int          sel = 0;
    logic        started = 1'b0;

    int n_chk = 0;
    int n_pass = 0;

    logic        o_fr [2];
    logic        o_pv [2];
    logic        o_dv [2];
    logic        o_err [2];
    logic [25:0] o_addr [2];
    logic [1:0]  o_param [2];
    logic [1:0]  o_mshr [2];
    logic [0:0]  o_cl0;
    logic [1:0]  o_cl1;

    always #5 clock = ~clock;

    broadcast_probe_issuer #(.N_CLIENTS(1)) u_dut1 (
        .clock                  (clock),
        .reset                  (reset),
        .io_filter_valid        (fv && (sel == 0)),
        .io_filter_ready        (o_fr[0]),
        .io_filter_bits_mshr    (mshr),
        .io_filter_bits_address (addr),
        .io_filter_bits_allocOH (alloc[0:0]),
        .io_filter_bits_needT   (need_t),
        .io_probe_valid         (o_pv[0]),
        .io_probe_ready         (pready),
        .io_probe_bits_address  (o_addr[0]),
        .io_probe_bits_param    (o_param[0]),
        .io_probe_bits_client   (o_cl0),
        .io_probeAck_valid      (ack && (sel == 0)),
        .io_done_valid          (o_dv[0]),
        .io_done_ready          (dready),
        .io_done_bits_mshr      (o_mshr[0]),
        .io_error               (o_err[0])
    );

    broadcast_probe_issuer #(.N_CLIENTS(4)) u_dut4 (
        .clock                  (clock),
        .reset                  (reset),
        .io_filter_valid        (fv && (sel == 1)),
        .io_filter_ready        (o_fr[1]),
        .io_filter_bits_mshr    (mshr),
        .io_filter_bits_address (addr),
        .io_filter_bits_allocOH (alloc),
        .io_filter_bits_needT   (need_t),
        .io_probe_valid         (o_pv[1]),
        .io_probe_ready         (pready),
        .io_probe_bits_address  (o_addr[1]),
        .io_probe_bits_param    (o_param[1]),
        .io_probe_bits_client   (o_cl1),
        .io_probeAck_valid      (ack && (sel == 1)),
        .io_done_valid          (o_dv[1]),
        .io_done_ready          (dready),
        .io_done_bits_mshr      (o_mshr[1]),
        .io_error               (o_err[1])
    );

    // Transaction model: a list of clients still to probe, an ack debt, a done flag.
    logic        m_busy [2] = '{1'b0, 1'b0};
    logic        m_done [2] = '{1'b0, 1'b0};
    logic        m_err  [2] = '{1'b0, 1'b0};
    logic        m_need [2] = '{1'b0, 1'b0};
    logic [25:0] m_addr [2] = '{26'd0, 26'd0};
    logic [1:0]  m_mshr [2] = '{2'd0, 2'd0};
    int          m_out  [2] = '{0, 0};
    int          m_head [2] = '{0, 0};
    int          m_len  [2] = '{0, 0};
    int          m_list [2][4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            logic fv_k, ack_k, idle, probing, waiting, pf;
            if (reset) begin
                m_busy[k] = 1'b0;
                m_done[k] = 1'b0;
                m_err[k]  = 1'b0;
                m_out[k]  = 0;
                m_head[k] = 0;
                m_len[k]  = 0;
            end else begin
                fv_k    = fv && (sel == k);
                ack_k   = ack && (sel == k);
                idle    = !m_busy[k];
                probing = m_busy[k] && !m_done[k] && (m_head[k] < m_len[k]);
                waiting = m_busy[k] && !m_done[k] && (m_head[k] == m_len[k]);
                pf      = probing && pready;
                if (pf && !ack_k) m_out[k]++;
                else if (ack_k && !pf) begin
                    if (m_out[k] > 0) m_out[k]--;
                    else m_err[k] = 1'b1;
                end
                if (idle && fv_k) begin
                    m_addr[k] = addr;
                    m_mshr[k] = mshr;
                    m_need[k] = need_t;
                    m_head[k] = 0;
                    m_len[k]  = 0;
                    for (int i = 0; i < ((k == 0) ? 1 : 4); i++) begin
                        if (alloc[i]) begin
                            m_list[k][m_len[k]] = i;
                            m_len[k]++;
                        end
                    end
                    m_busy[k] = 1'b1;
                    m_done[k] = (m_len[k] == 0);
                end else if (pf) begin
                    m_head[k]++;
                    if (m_head[k] == m_len[k] && m_out[k] == 0) m_done[k] = 1'b1;
                end else if (waiting && m_out[k] == 0) begin
                    m_done[k] = 1'b1;
                end else if (m_done[k] && dready) begin
                    m_busy[k] = 1'b0;
                    m_done[k] = 1'b0;
                end
            end
        end
    endtask

    task automatic compare();
        for (int k = 0; k < 2; k++) begin
            logic        probing;
            logic [31:0] cl;
            probing = m_busy[k] && !m_done[k] && (m_head[k] < m_len[k]);
            cl = (k == 0) ? 32'(o_cl0) : 32'(o_cl1);
            chk($sformatf("d%0d_filter_ready", k), 32'(o_fr[k]), 32'(!m_busy[k]));
            chk($sformatf("d%0d_probe_valid", k), 32'(o_pv[k]), 32'(probing));
            chk($sformatf("d%0d_done_valid", k), 32'(o_dv[k]), 32'(m_done[k]));
            chk($sformatf("d%0d_error", k), 32'(o_err[k]), 32'(m_err[k]));
            if (probing) begin
                chk($sformatf("d%0d_probe_addr", k), 32'(o_addr[k]), 32'(m_addr[k]));
                chk($sformatf("d%0d_probe_param", k), 32'(o_param[k]),
                    m_need[k] ? 32'd2 : 32'd1);
                chk($sformatf("d%0d_probe_client", k), cl, 32'(m_list[k][m_head[k]]));
            end
            if (m_done[k]) begin
                chk($sformatf("d%0d_done_mshr", k), 32'(o_mshr[k]), 32'(m_mshr[k]));
            end
        end
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    initial forever begin
        @(negedge clock);
        if (started) compare();
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        tick();
        started = 1'b1;
        tick();
        chk("reset_filter_ready", 32'(o_fr[1]), 32'd1);
        chk("reset_probe_valid", 32'(o_pv[1]), 32'd0);
        chk("reset_done_valid", 32'(o_dv[1]), 32'd0);
        chk("reset_error", 32'(o_err[1]), 32'd0);
        reset = 1'b0;

        // Empty mask: done one cycle after the filter fires.
        sel = 1; fv = 1'b1; alloc = 4'b0000; mshr = 2'd2; addr = 26'h123_4567; need_t = 1'b0;
        tick();
        fv = 1'b0;
        chk("empty_done_valid", 32'(o_dv[1]), 32'd1);
        chk("empty_done_mshr", 32'(o_mshr[1]), 32'd2);
        chk("empty_no_probe", 32'(o_pv[1]), 32'd0);
        tick();

        // One client, needT, zero-wait ack.
        sel = 0; fv = 1'b1; alloc = 4'b0001; mshr = 2'd1; addr = 26'h3FF_FFC0; need_t = 1'b1;
        tick();
        fv = 1'b0;
        chk("one_probe_valid", 32'(o_pv[0]), 32'd1);
        chk("one_param_toN", 32'(o_param[0]), 32'd2);
        chk("one_client", 32'(o_cl0), 32'd0);
        chk("one_addr", 32'(o_addr[0]), 32'h3FF_FFC0);
        tick();
        ack = 1'b1;
        chk("one_wait_no_done", 32'(o_dv[0]), 32'd0);
        tick();
        ack = 1'b0;
        chk("one_done_t3", 32'(o_dv[0]), 32'd1);
        chk("one_done_mshr", 32'(o_mshr[0]), 32'd1);
        tick();

        // toB probe stalled by probe_ready low.
        fv = 1'b1; alloc = 4'b0001; mshr = 2'd3; addr = 26'h0A5_5A5A; need_t = 1'b0;
        pready = 1'b0;
        tick();
        fv = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_probe_valid", 32'(o_pv[0]), 32'd1);
            chk("stall_param_toB", 32'(o_param[0]), 32'd1);
            chk("stall_addr", 32'(o_addr[0]), 32'h0A5_5A5A);
            chk("stall_filter_ready", 32'(o_fr[0]), 32'd0);
            tick();
        end
        pready = 1'b1;
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();

        // Four clients, mask 1010, overlapping ack and second probe.
        sel = 1; fv = 1'b1; alloc = 4'b1010; mshr = 2'd3; addr = 26'h0AB_CDEF; need_t = 1'b1;
        tick();
        fv = 1'b0;
        chk("multi_first_client", 32'(o_cl1), 32'd1);
        tick();
        chk("multi_second_client", 32'(o_cl1), 32'd3);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("multi_wait_no_probe", 32'(o_pv[1]), 32'd0);
        chk("multi_wait_no_done", 32'(o_dv[1]), 32'd0);
        tick();
        chk("multi_still_wait", 32'(o_dv[1]), 32'd0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("multi_done_valid", 32'(o_dv[1]), 32'd1);
        dready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("multi_done_held", 32'(o_dv[1]), 32'd1);
            chk("multi_done_mshr", 32'(o_mshr[1]), 32'd3);
        end
        dready = 1'b1;
        tick();
        chk("multi_back_idle", 32'(o_fr[1]), 32'd1);

        // Spurious ack in IDLE latches the error flag.
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("spurious_error", 32'(o_err[1]), 32'd1);
        tick();
        chk("error_sticky", 32'(o_err[1]), 32'd1);

        // Reset while waiting for an ack.
        fv = 1'b1; alloc = 4'b0100; mshr = 2'd0; addr = 26'h000_0040; need_t = 1'b0;
        tick();
        fv = 1'b0;
        tick();
        chk("pre_reset_wait", 32'(o_fr[1]), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("post_reset_ready", 32'(o_fr[1]), 32'd1);
        chk("post_reset_error", 32'(o_err[1]), 32'd0);
        chk("post_reset_done", 32'(o_dv[1]), 32'd0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("late_ack_error", 32'(o_err[1]), 32'd1);
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
